// File: rtl/lms_ctr_mem_stream_reader.sv
// Avalon-MM read master that streams a block of on-chip memory words out as an Avalon-ST packet.
// Reads are credit-limited against a 2-entry output FIFO; the memory return can bypass an empty FIFO.
module lms_ctr_mem_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   issue_left_r;
    logic [ADDR_W:0]   deliver_left_r;
    logic              inflight_r;
    logic              first_r;
    logic              busy_r;
    logic              done_r;
    logic              cs_r;
    logic [DATA_W-1:0] fifo_mem_r [2];
    logic              fifo_wr_ptr_r;
    logic              fifo_rd_ptr_r;
    logic [1:0]        fifo_cnt_r;

    logic              accept_s;
    logic              abort_s;
    logic              pop_s;
    logic              last_pop_s;
    logic              fifo_pop_s;
    logic              fifo_wr_s;
    logic              issue_s;
    logic [2:0]        occupancy_s;
    logic [ADDR_W:0]   load_count_s;
    logic [ADDR_W:0]   issue_left_next_s;
    logic [ADDR_W-1:0] issue_addr_s;

    assign busy           = busy_r;
    assign done           = done_r;
    assign mem_address    = addr_r;
    assign mem_chipselect = cs_r;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    // Source side: FIFO head, or the memory return directly when the FIFO is empty.
    always_comb begin
        src_valid = (fifo_cnt_r != 2'd0) || inflight_r;
        if (fifo_cnt_r != 2'd0) begin
            src_data = fifo_mem_r[fifo_rd_ptr_r];
        end else if (inflight_r) begin
            src_data = mem_readdata;
        end else begin
            src_data = {DATA_W{1'b0}};
        end
        src_sop = src_valid && first_r;
        src_eop = src_valid && (deliver_left_r == CNT_ONE);
    end

    // Issue decision: the read issued here is presented next cycle and returns the cycle after,
    // so a word counts against the 2-entry budget from issue until it is popped.
    always_comb begin
        accept_s     = start && (state_r == IDLE);
        abort_s      = abort && (state_r != IDLE);
        pop_s        = src_valid && src_ready;
        last_pop_s   = pop_s && (deliver_left_r == CNT_ONE);
        fifo_pop_s   = pop_s && (fifo_cnt_r != 2'd0);
        fifo_wr_s    = inflight_r && !(pop_s && (fifo_cnt_r == 2'd0));
        occupancy_s  = {1'b0, fifo_cnt_r} + {2'b00, cs_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        load_count_s = (word_count == CNT_ZERO) ? CNT_MAX : word_count;
        issue_addr_s = accept_s ? start_addr : rd_addr_r;
        issue_s      = !abort_s && (occupancy_s < 3'd2) &&
                       (accept_s || ((state_r == RUN) && (issue_left_r != CNT_ZERO)));
        if (accept_s) begin
            issue_left_next_s = load_count_s - (issue_s ? CNT_ONE : CNT_ZERO);
        end else if (issue_s) begin
            issue_left_next_s = issue_left_r - CNT_ONE;
        end else begin
            issue_left_next_s = issue_left_r;
        end
    end

    // Control FSM, read-issue registers and output FIFO.
    always_ff @(posedge clk) begin
        if (reset || abort_s) begin
            state_r        <= IDLE;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            cs_r           <= 1'b0;
            inflight_r     <= 1'b0;
            first_r        <= 1'b0;
            issue_left_r   <= CNT_ZERO;
            deliver_left_r <= CNT_ZERO;
            fifo_wr_ptr_r  <= 1'b0;
            fifo_rd_ptr_r  <= 1'b0;
            fifo_cnt_r     <= 2'd0;
            if (reset) begin
                rd_addr_r     <= {ADDR_W{1'b0}};
                addr_r        <= {ADDR_W{1'b0}};
                fifo_mem_r[0] <= {DATA_W{1'b0}};
                fifo_mem_r[1] <= {DATA_W{1'b0}};
            end else begin
                rd_addr_r <= rd_addr_r;
                addr_r    <= addr_r;
            end
        end else begin
            done_r       <= 1'b0;
            cs_r         <= issue_s;
            inflight_r   <= cs_r;
            issue_left_r <= issue_left_next_s;

            if (issue_s) begin
                addr_r    <= issue_addr_s;
                rd_addr_r <= issue_addr_s + ADDR_ONE;
            end else if (accept_s) begin
                rd_addr_r <= start_addr;
            end else begin
                rd_addr_r <= rd_addr_r;
            end

            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= (issue_left_next_s == CNT_ZERO) ? DRAIN : RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    state_r <= (issue_left_next_s == CNT_ZERO) ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (last_pop_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            if (accept_s) begin
                deliver_left_r <= load_count_s;
                first_r        <= 1'b1;
            end else if (pop_s) begin
                deliver_left_r <= deliver_left_r - CNT_ONE;
                first_r        <= 1'b0;
            end else begin
                deliver_left_r <= deliver_left_r;
            end

            if (fifo_wr_s) begin
                fifo_mem_r[fifo_wr_ptr_r] <= mem_readdata;
                fifo_wr_ptr_r             <= ~fifo_wr_ptr_r;
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, fifo_wr_s} - {1'b0, fifo_pop_s};
        end
    end
endmodule

// File: tb/tb_lms_ctr_mem_stream_reader.sv
// Scoreboard bench: the driver queues each expected packet, the monitor checks every handshake.
module tb_lms_ctr_mem_stream_reader;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  start_addr = 10'd0;
    logic [10:0] word_count = 11'd0;
    logic        abort = 1'b0;
    logic        src_ready = 1'b0;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] src_data;
    logic        src_valid, src_sop, src_eop;

    logic [31:0] mem [DEPTH];
    int tests_run = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int pat_idx = 0;

    logic [31:0] exp_data_q [$];
    logic        exp_sop_q [$];
    logic        exp_eop_q [$];
    logic [9:0]  exp_addr_q [$];

    lms_ctr_mem_stream_reader #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // On-chip memory model: readdata one cycle after the address.
    always @(posedge clk) if (mem_clken) mem_readdata <= mem[mem_address];

    // Downstream sink ready patterns.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: src_ready = 1'b1;
            1: begin
                src_ready = (pat_idx == 0) || (pat_idx == 3);
                pat_idx = (pat_idx + 1) % 4;
            end
            2: src_ready = ($urandom_range(0, 3) != 0);
            default: src_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_sop = 1'b0, prev_eop = 1'b0;
    logic        chk_idle = 1'b0;
    int issued = 0, popped = 0, last_eop_cyc = -10;
    always @(negedge clk) begin
        if (reset) begin
            exp_data_q.delete(); exp_sop_q.delete(); exp_eop_q.delete(); exp_addr_q.delete();
            issued = 0; popped = 0; prev_stall = 1'b0; chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("abort_busy", busy, 1'b0);
                check("abort_valid", src_valid, 1'b0);
                chk_idle = 1'b0;
            end
            if (mem_chipselect) begin
                issued++;
                tests_run++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_issue: read at %0h with none expected", mem_address);
                end else if (mem_address !== exp_addr_q[0]) begin
                    failures++;
                    $display("FAIL issue_addr: got %0h, expected %0h", mem_address, exp_addr_q[0]);
                    void'(exp_addr_q.pop_front());
                end else begin
                    void'(exp_addr_q.pop_front());
                end
                check("buffered_le_2", (issued - popped > 2), 1'b0);
            end
            if (prev_stall) begin
                check("stall_valid", src_valid, 1'b1);
                check("stall_data", src_data, prev_data);
                check("stall_sop", src_sop, prev_sop);
                check("stall_eop", src_eop, prev_eop);
            end
            if (src_valid && src_ready) begin
                popped++;
                tests_run++;
                if (exp_data_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word: got %0h with no word expected", src_data);
                end else begin
                    tests_run--;
                    check("data", src_data, exp_data_q.pop_front());
                    check("sop", src_sop, exp_sop_q.pop_front());
                    check("eop", src_eop, exp_eop_q.pop_front());
                    if (src_eop) last_eop_cyc = cyc;
                end
            end
            if (done) begin
                check("done_after_eop", cyc, last_eop_cyc + 1);
                check("done_all_words", exp_data_q.size(), 0);
                check("done_busy_low", busy, 1'b0);
            end
            prev_stall = src_valid && !src_ready;
            prev_data = src_data; prev_sop = src_sop; prev_eop = src_eop;
            if (abort && busy) begin
                exp_data_q.delete(); exp_sop_q.delete(); exp_eop_q.delete(); exp_addr_q.delete();
                issued = 0; popped = 0; prev_stall = 1'b0; chk_idle = 1'b1;
            end
        end
    end

    task automatic start_xfer(input logic [9:0] a, input logic [10:0] n, output int t);
        int len;
        len = (n == 11'd0) ? DEPTH : int'(n);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; word_count = n;
        for (int i = 0; i < len; i++) begin
            exp_data_q.push_back(mem[(int'(a) + i) % DEPTH]);
            exp_sop_q.push_back(i == 0);
            exp_eop_q.push_back(i == len - 1);
            exp_addr_q.push_back(10'((int'(a) + i) % DEPTH));
        end
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        tests_run++;
        if (dcyc < 0) begin
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_valid"}, src_valid, 1'b0);
        check({tag, "_sop"}, src_sop, 1'b0);
        check({tag, "_eop"}, src_eop, 1'b0);
        check({tag, "_cs"}, mem_chipselect, 1'b0);
        check({tag, "_addr"}, mem_address, 10'd0);
        check({tag, "_data"}, src_data, 32'd0);
    endtask

    initial begin
        int t, d, hs;
        for (int i = 0; i < DEPTH; i++) mem[i] = i * 32'h01010101;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("mem_write", mem_write, 1'b0);
        check("mem_byteenable", mem_byteenable, 4'hF);
        check("mem_clken", mem_clken, 1'b1);

        // Basic packet with latency checks.
        rdy_mode = 0;
        start_xfer(10'h010, 11'd4, t);
        @(negedge clk);
        check("busy_t1", busy, 1'b1);
        check("cs_t1", mem_chipselect, 1'b1);
        check("addr_t1", mem_address, 10'h010);
        check("valid_t1", src_valid, 1'b0);
        @(negedge clk);
        check("valid_t2", src_valid, 1'b1);
        check("data_t2", src_data, 32'h10101010);
        wait_done(50, d);
        check("done_cycle", d, t + 6);

        // Address wrap.
        start_xfer(10'h3FE, 11'd4, t);
        wait_done(50, d);
        check("wrap_done_cycle", d, t + 6);

        // Backpressure 1,0,0,1.
        rdy_mode = 1;
        start_xfer(10'h100, 11'd8, t);
        wait_done(200, d);

        // Count 0 means 1024 words.
        rdy_mode = 2;
        start_xfer(10'h2A0, 11'd0, t);
        wait_done(5000, d);

        // Abort after 3 accepted words with the sink stalled.
        rdy_mode = 0;
        start_xfer(10'h050, 11'd10, t);
        hs = 0;
        for (int k = 0; k < 40 && hs < 3; k++) begin
            @(negedge clk);
            if (src_valid && src_ready) hs++;
        end
        check("abort_setup_words", hs, 3);
        rdy_mode = 3;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_done_after_abort", done, 1'b0);
        end
        rdy_mode = 0;
        start_xfer(10'h060, 11'd2, t);
        wait_done(50, d);
        check("post_abort_done_cycle", d, t + 4);

        // Reset mid-packet.
        start_xfer(10'h120, 11'd6, t);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");

        // Start while busy is ignored.
        rdy_mode = 1;
        start_xfer(10'h200, 11'd5, t);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 start = 1'b1; start_addr = 10'h300; word_count = 11'd9;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, d);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_after_len5_valid", src_valid, 1'b0);
            check("idle_after_len5_busy", busy, 1'b0);
        end

        // Randomised packets over random memory contents.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int r = 0; r < 8; r++) begin
            rdy_mode = $urandom_range(0, 2);
            start_xfer(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 24)), t);
            wait_done(400, d);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
